// File: rtl/ste_joypad_ports.sv
// STE enhanced-joystick port block: maps 1..2 HID pad states onto the active-low STE
// select/data matrix with synchronised select rows, registered outputs, autofire and pad swap.
module ste_joypad_ports #(
    parameter int NUM_PADS     = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int AUTOFIRE_DIV = 40000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [16*NUM_PADS-1:0]  joy,
    input  logic [4*NUM_PADS-1:0]   af_mask,
    input  logic                    swap,
    input  logic [4*NUM_PADS-1:0]   din,
    output logic [8*NUM_PADS-1:0]   dout,
    output logic [2*NUM_PADS-1:0]   buttons
);

    localparam int DIV_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTOFIRE_DIV - 1);

    logic [SYNC_STAGES-1:0][4*NUM_PADS-1:0] sync_q;
    logic [4*NUM_PADS-1:0]  ds;
    logic [16*NUM_PADS-1:0] joy_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   af_phase_q, af_phase_d;
    logic [13:0]            eff [NUM_PADS];
    logic [8*NUM_PADS-1:0]  dout_q, dout_d;
    logic [2*NUM_PADS-1:0]  buttons_q, buttons_d;
    logic [2*NUM_PADS-1:0]  unused_joy_hi;

    // Select rows are idle-high, so the synchroniser resets to "no row active".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign ds = sync_q[SYNC_STAGES-1];

    always_comb begin
        div_d      = div_q + 1'b1;
        af_phase_d = af_phase_q;
        if (div_q == DIV_LAST) begin
            div_d      = '0;
            af_phase_d = ~af_phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy_q      <= '0;
            div_q      <= '0;
            af_phase_q <= 1'b1;
            dout_q     <= '1;
            buttons_q  <= '1;
        end else begin
            joy_q      <= joy;
            div_q      <= div_d;
            af_phase_q <= af_phase_d;
            dout_q     <= dout_d;
            buttons_q  <= buttons_d;
        end
    end

    // Autofire gates only the four face/shoulder bits 7..4 of each pad.
    always_comb begin
        for (int p = 0; p < NUM_PADS; p++) begin
            eff[p] = joy_q[16*p +: 14];
            for (int k = 0; k < 4; k++) begin
                if (af_mask[4*p+k] && !af_phase_q) begin
                    eff[p][4+k] = 1'b0;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_port
            logic [13:0] j;
            logic [3:0]  r;

            assign unused_joy_hi[2*gi +: 2] = joy_q[16*gi+14 +: 2];
            // With one pad the "other" index is the pad itself, so swap has no effect.
            assign j = swap ? eff[NUM_PADS-1-gi] : eff[gi];
            assign r = ~ds[4*gi +: 4];

            assign dout_d[8*gi+7]   = ~(r[0] & j[0]);
            assign dout_d[8*gi+6]   = ~((r[3] & j[11]) | (r[1] & j[10]) | (r[0] & j[1]));
            assign dout_d[8*gi+5]   = ~((r[3] & j[8]) | (r[2] & j[9]) | (r[1] & j[12]) | (r[0] & j[2]));
            assign dout_d[8*gi+4]   = ~(r[0] & j[3]);
            assign dout_d[8*gi +: 4] = 4'hF;
            assign buttons_d[2*gi+1] = ~((r[3] & j[7]) | (r[2] & j[6]) | (r[1] & j[5]) | (r[0] & j[4]));
            assign buttons_d[2*gi]   = ~(r[0] & j[13]);
        end
    endgenerate

    assign dout    = dout_q;
    assign buttons = buttons_q;

endmodule

// File: tb/tb_ste_joypad_ports.sv
// Bench for ste_joypad_ports: hand-derived matrix vectors, latency/autofire/swap/reset
// sequences, and randomized traffic against a cycle-indexed history model.
module tb_ste_joypad_ports;

    localparam int NP = 2;
    localparam int SS = 2;
    localparam int AD = 4;
    localparam int HN = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] joy = '1;
    logic [7:0]  af_mask = '0;
    logic        swap = 1'b0;
    logic [7:0]  din = '0;
    logic [15:0] dout;
    logic [3:0]  buttons;

    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [7:0]  din_h  [HN];
    logic [31:0] joy_h  [HN];
    logic [7:0]  mask_h [HN];
    logic        swap_h [HN];

    typedef struct {
        logic [15:0] joy0;
        logic [3:0]  din0;
        logic [7:0]  dexp;
        logic [1:0]  bexp;
    } vec_t;
    vec_t vecs [18];

    ste_joypad_ports #(.NUM_PADS(NP), .SYNC_STAGES(SS), .AUTOFIRE_DIV(AD)) dut (
        .clk(clk), .reset_n(reset_n), .joy(joy), .af_mask(af_mask), .swap(swap),
        .din(din), .dout(dout), .buttons(buttons)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Record the inputs seen by the next edge, take the edge, settle.
    task automatic tick();
        if (n < HN - 2) begin
            din_h[n+1]  = din;
            joy_h[n+1]  = joy;
            mask_h[n+1] = af_mask;
            swap_h[n+1] = swap;
        end
        @(posedge clk);
        n++;
        #1;
    endtask

    // Asserts reset mid-cycle, checks the outputs clear at once, releases between edges.
    task automatic do_reset(input logic [31:0] j, input logic [7:0] d, input logic [7:0] m, input logic s);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_dout", {16'h0, dout}, 32'hFFFF);
        chk("async_reset_btn", {28'h0, buttons}, 32'hF);
        joy = j; din = d; af_mask = m; swap = s;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        n = 0;
    endtask

    // Expected outputs after edge k since reset release, derived from the input history.
    function automatic void model(input int k, output logic [15:0] d, output logic [3:0] b);
        int tout [14] = '{0, 1, 1, 1, 1, 2, 2, 2, 3, 4, 4, 4, 4, 5};
        int trow [14] = '{0, 3, 2, 1, 0, 3, 1, 0, 0, 3, 2, 1, 0, 0};
        int tbit [14] = '{3, 8, 9, 12, 2, 11, 10, 1, 0, 7, 6, 5, 4, 13};
        logic [7:0]  rows;
        logic [31:0] jr;
        logic [15:0] j;
        logic [5:0]  act;
        logic        ph;
        int          src;
        rows = (k >= SS + 1) ? din_h[k-SS] : 8'hFF;
        jr   = (k >= 2) ? joy_h[k-1] : 32'h0;
        ph   = (((k - 1) / AD) % 2) == 0;
        for (int p = 0; p < NP; p++) begin
            src = swap_h[k] ? (1 - p) : p;
            j = jr[16*src +: 16];
            for (int q = 0; q < 4; q++) begin
                if (mask_h[k][4*src+q] && !ph) j[4+q] = 1'b0;
            end
            act = '0;
            for (int t = 0; t < 14; t++) begin
                if (!rows[4*p+trow[t]] && j[tbit[t]]) act[tout[t]] = 1'b1;
            end
            d[8*p +: 8] = {~act[3], ~act[2], ~act[1], ~act[0], 4'hF};
            b[2*p +: 2] = {~act[4], ~act[5]};
        end
    endfunction

    task automatic af_seq();
        int af_exp [14] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        do_reset(32'h0000_0010, 8'hFE, 8'h01, 1'b0);
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e >= 3) begin
                chk($sformatf("autofire_e%0d", e), {31'h0, buttons[1]}, af_exp[e-3]);
                $display("autofire edge %0d: buttons=%b", e, buttons);
            end
        end
        af_mask = 8'h00;
        for (int e = 0; e < 6; e++) begin
            tick();
            chk("autofire_off_steady", {31'h0, buttons[1]}, 32'h0);
        end
        $display("autofire mask cleared: buttons=%b", buttons);
    endtask

    initial begin
        logic [15:0] de;
        logic [3:0]  be;

        vecs[0]  = '{16'h0001, 4'hE, 8'h7F, 2'b11};
        vecs[1]  = '{16'h0120, 4'hC, 8'hFF, 2'b01};
        vecs[2]  = '{16'h0120, 4'hB, 8'hFF, 2'b11};
        vecs[3]  = '{16'h0120, 4'h7, 8'hDF, 2'b11};
        vecs[4]  = '{16'hFFFF, 4'hF, 8'hFF, 2'b11};
        vecs[5]  = '{16'hFFFF, 4'h0, 8'h0F, 2'b00};
        vecs[6]  = '{16'h2000, 4'hE, 8'hFF, 2'b10};
        vecs[7]  = '{16'h0008, 4'hE, 8'hEF, 2'b11};
        vecs[8]  = '{16'h0004, 4'hE, 8'hDF, 2'b11};
        vecs[9]  = '{16'h0002, 4'hE, 8'hBF, 2'b11};
        vecs[10] = '{16'h0400, 4'hD, 8'hBF, 2'b11};
        vecs[11] = '{16'h1000, 4'hD, 8'hDF, 2'b11};
        vecs[12] = '{16'h0200, 4'hB, 8'hDF, 2'b11};
        vecs[13] = '{16'h0800, 4'h7, 8'hBF, 2'b11};
        vecs[14] = '{16'h0080, 4'h7, 8'hFF, 2'b01};
        vecs[15] = '{16'h0040, 4'hB, 8'hFF, 2'b01};
        vecs[16] = '{16'h0010, 4'hE, 8'hFF, 2'b01};
        vecs[17] = '{16'hFFFF, 4'hE, 8'h0F, 2'b00};

        // Reset held with every button pressed and every row selected.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", {16'h0, dout}, 32'hFFFF);
        chk("reset_btn", {28'h0, buttons}, 32'hF);
        din = 8'hFF;
        #1;
        reset_n = 1'b1;
        n = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("release_idle_dout", {16'h0, dout}, 32'hFFFF);
            chk("release_idle_btn", {28'h0, buttons}, 32'hF);
        end
        $display("reset/release idle: dout=%h buttons=%b", dout, buttons);

        // Select-to-data latency.
        do_reset(32'h0000_0001, 8'hFF, 8'h00, 1'b0);
        repeat (4) tick();
        din = 8'hFE;
        tick();
        chk("latency_e1", {24'h0, dout[7:0]}, 32'hFF);
        tick();
        chk("latency_e2", {24'h0, dout[7:0]}, 32'hFF);
        tick();
        chk("latency_e3", {24'h0, dout[7:0]}, 32'h7F);
        chk("latency_port1", {24'h0, dout[15:8]}, 32'hFF);
        $display("latency: dout=%h after 3 edges", dout);

        // Static matrix vectors on port 0.
        for (int v = 0; v < 18; v++) begin
            joy = {16'h0000, vecs[v].joy0};
            din = {4'hF, vecs[v].din0};
            repeat (4) tick();
            chk($sformatf("vec%0d_dout", v), {24'h0, dout[7:0]}, {24'h0, vecs[v].dexp});
            chk($sformatf("vec%0d_btn", v), {30'h0, buttons[1:0]}, {30'h0, vecs[v].bexp});
            chk($sformatf("vec%0d_port1", v), {20'h0, dout[15:8], buttons[3:2]}, {20'h0, 8'hFF, 2'b11});
            $display("vec %0d: joy0=%h din0=%h -> dout0=%h buttons0=%b", v, vecs[v].joy0, vecs[v].din0, dout[7:0], buttons[1:0]);
        end

        // Pad swap.
        joy = 32'h0010_0000; din = 8'hFE; af_mask = 8'h00; swap = 1'b1;
        repeat (4) tick();
        chk("swap_on_btn0", {30'h0, buttons[1:0]}, 32'h1);
        chk("swap_on_btn1", {30'h0, buttons[3:2]}, 32'h3);
        swap = 1'b0;
        tick();
        chk("swap_off_btn0", {30'h0, buttons[1:0]}, 32'h3);
        $display("swap: buttons=%b after swap cleared", buttons);

        // Autofire, then reset mid-autofire with rows active and rerun from a clean divider.
        af_seq();
        af_mask = 8'h01;
        repeat (5) tick();
        af_seq();

        // Randomized traffic against the history model, with one reset midway.
        do_reset($urandom, 8'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset($urandom, 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
            model(n, de, be);
            chk($sformatf("rand%0d_dout", i), {16'h0, dout}, {16'h0, de});
            chk($sformatf("rand%0d_btn", i), {28'h0, buttons}, {28'h0, be});
            $display("rand %0d: joy=%h din=%h mask=%h swap=%b -> dout=%h buttons=%b", i, joy, din, af_mask, swap, dout, buttons);
            joy = $urandom;
            if ($urandom_range(3) == 0) din = 8'($urandom);
            if ($urandom_range(7) == 0) af_mask = 8'($urandom);
            if ($urandom_range(7) == 0) swap = 1'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
